// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, EX redirect, LSU back-pressure
// and trap entry with a multi-cycle drain, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int TRAP_DRAIN = 2,
    parameter int PERF_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_useRs1,
    input  logic              id_useRs2,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regWrEn,
    input  logic [1:0]        ex_resultSrc,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    input  logic              exc_valid,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [1:0]        pc_sel,
    output logic [1:0]        state,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    // state | meaning
    // RUN   | normal issue; hazards resolved by priority
    // TRAP  | full-pipeline flush for TRAP_DRAIN cycles after exception
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN - 1);

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       lu;
    logic       flush_event;

    assign lu = id_valid & ex_valid & ex_regWrEn & (ex_resultSrc == 2'b01) &
                (ex_rd != 5'd0) &
                ((id_useRs1 & (id_rs1 == ex_rd)) | (id_useRs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_stall    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        pc_sel      = 2'd0;
        flush_event = 1'b0;
        unique case (state_q)
            RUN: begin
                if (exc_valid) begin
                    pc_sel      = 2'd2;
                    id_flush    = 1'b1;
                    ex_flush    = 1'b1;
                    mem_flush   = 1'b1;
                    flush_event = 1'b1;
                    state_d     = TRAP;
                    drain_d     = DRAIN_INIT;
                end else if (mem_busy) begin
                    // Redirect and load-use stay pending; their inputs are held by the stall.
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_stall = 1'b1;
                end else if (ex_redirect) begin
                    pc_sel      = 2'd1;
                    id_flush    = 1'b1;
                    ex_flush    = 1'b1;
                    flush_event = 1'b1;
                end else if (lu) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end
            end
            TRAP: begin
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
                if (drain_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                drain_d = 4'd0;
            end
        endcase
        if (reset) begin
            if_stall    = 1'b0;
            id_stall    = 1'b0;
            ex_stall    = 1'b0;
            id_flush    = 1'b0;
            ex_flush    = 1'b0;
            mem_flush   = 1'b0;
            pc_sel      = 2'd0;
            flush_event = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (if_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_event && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level priority model with counters and a trap countdown.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 2;
    localparam int PW    = 8;
    localparam int MAXC  = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid, id_useRs1, id_useRs2, ex_valid, ex_regWrEn;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic [1:0]    ex_resultSrc;
    logic          ex_redirect, mem_busy, exc_valid;
    logic          if_stall, id_stall, ex_stall, id_flush, ex_flush, mem_flush;
    logic [1:0]    pc_sel, state;
    logic [PW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    int m_trap  = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.TRAP_DRAIN(DRAIN), .PERF_W(PW)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regWrEn(ex_regWrEn),
        .ex_resultSrc(ex_resultSrc), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .exc_valid(exc_valid),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .pc_sel(pc_sel), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic ev, input logic [4:0] rd,
                        input logic wr, input logic [1:0] src, input logic redir,
                        input logic busy, input logic exc);
        logic lu;
        logic e_is, e_ids, e_exs, e_idf, e_exf, e_mf;
        int   e_pc;
        bit   inc_s, inc_f, enter;
        @(negedge clock);
        reset = rst; id_valid = iv; id_rs1 = rs1; id_rs2 = rs2; id_useRs1 = u1; id_useRs2 = u2;
        ex_valid = ev; ex_rd = rd; ex_regWrEn = wr; ex_resultSrc = src;
        ex_redirect = redir; mem_busy = busy; exc_valid = exc;
        #2;
        lu = iv && ev && wr && (src == 2'b01) && (rd != 0) &&
             ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        {e_is, e_ids, e_exs, e_idf, e_exf, e_mf} = '0;
        e_pc = 0; inc_s = 0; inc_f = 0; enter = 0;
        if (rst) begin
            m_trap = 0; m_stall = 0; m_flush = 0;
        end else if (m_trap > 0) begin
            {e_idf, e_exf, e_mf} = 3'b111;
        end else if (exc) begin
            e_pc = 2; {e_idf, e_exf, e_mf} = 3'b111; inc_f = 1; enter = 1;
        end else if (busy) begin
            {e_is, e_ids, e_exs} = 3'b111; inc_s = 1;
        end else if (redir) begin
            e_pc = 1; {e_idf, e_exf} = 2'b11; inc_f = 1;
        end else if (lu) begin
            {e_is, e_ids, e_exf} = 3'b111; inc_s = 1;
        end
        check("if_stall",  32'(if_stall),  32'(e_is));
        check("id_stall",  32'(id_stall),  32'(e_ids));
        check("ex_stall",  32'(ex_stall),  32'(e_exs));
        check("id_flush",  32'(id_flush),  32'(e_idf));
        check("ex_flush",  32'(ex_flush),  32'(e_exf));
        check("mem_flush", 32'(mem_flush), 32'(e_mf));
        check("pc_sel",    32'(pc_sel),    32'(e_pc));
        check("state",     32'(state),     (m_trap > 0) ? 32'd1 : 32'd0);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        if (!rst) begin
            if (m_trap > 0) m_trap--;
            else if (enter) m_trap = DRAIN;
            if (inc_s && m_stall < MAXC) m_stall++;
            if (inc_f && m_flush < MAXC) m_flush++;
        end
    endtask

    task automatic idle(input logic redir, input logic exc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, redir, 0, exc);
    endtask

    initial begin
        reset = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        // load x5 in EX, ID add reads rs2=x5, then the load advances
        step(0, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 2'b01, 0, 0, 0);
        step(0, 1, 5'd1, 5'd5, 1, 1, 0, 5'd0, 0, 2'b00, 0, 0, 0);
        // rd = x0 and rs2 not used: no interlock
        step(0, 1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 2'b01, 0, 0, 0);
        step(0, 1, 5'd1, 5'd5, 1, 0, 1, 5'd5, 1, 2'b01, 0, 0, 0);
        // redirect wins over load-use
        step(0, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 2'b01, 1, 0, 0);
        // back-pressure holds a redirect for three cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 2'b00, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 2'b00, 1, 0, 0);
        // trap entry, drain ignores redirect/exception pulses
        idle(0, 1);
        idle(1, 0);
        idle(0, 1);
        idle(0, 0);
        idle(0, 0);
        // reset asserted during the drain
        idle(0, 1);
        idle(0, 0);
        step(1, 1, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 2'b01, 1, 1, 1);
        idle(0, 0);
        // random traffic; resets only early so counters can reach saturation later
        for (int c = 0; c < 3000; c++) begin
            logic r;
            r = (c < 500) && ($urandom_range(0, 99) == 0);
            step(r, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 2'($urandom), $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
        end
        check("stall_sat", 32'(stall_cnt), 32'(MAXC));
        check("flush_sat", 32'(flush_cnt), 32'(MAXC));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
